// File: rtl/if_id_ex_pipeline.sv
// if_id_ex_pipeline: IF, ID and EX stages of an in-order RV32I core.
// Holds the PC, a 256x32 instruction memory, the IF/ID, ID/EX and EX/MEM
// registers, a 32x32 register file, the ALU and branch resolution.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_wen_i/waddr_i/wdata_i    byte-enabled instruction-memory write port
//   stall_i                       hold PC and IF/ID, bubble into ID/EX
//   wb_we_i/wb_rd_i/wb_data_i     register-file write port
//   instr_o, format_o             IF/ID instruction and its decoded format
//   flush_o                       taken branch/jump in EX (combinational)
//   ex_*_o                        EX/MEM register contents
module if_id_ex_pipeline (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  imem_wen_i,
   input  logic [7:0]  imem_waddr_i,
   input  logic [31:0] imem_wdata_i,
   input  logic        stall_i,
   input  logic        wb_we_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_data_i,
   output logic [31:0] instr_o,
   output logic [2:0]  format_o,
   output logic        flush_o,
   output logic        ex_valid_o,
   output logic [31:0] ex_pc_o,
   output logic [31:0] ex_instr_o,
   output logic [4:0]  ex_rd_o,
   output logic        ex_rf_wr_en_o,
   output logic [31:0] ex_result_o,
   output logic [3:0]  ex_mem_op_o,
   output logic [31:0] ex_store_data_o
);
   localparam int unsigned XLEN       = 32;
   localparam int unsigned IMEM_DEPTH = 256;
   localparam int unsigned NREG       = 32;
   localparam logic [XLEN-1:0] NOP    = 32'h0000_0013;

   typedef enum logic [2:0] {K_ALU, K_LUI, K_AUIPC, K_LOAD, K_STORE, K_JAL, K_JALR, K_BRANCH} kind_e;
   typedef enum logic [3:0] {A_ADD, A_SUB, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_SRA, A_OR, A_AND} alu_e;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic [4:0]      rd;
      logic [XLEN-1:0] rs1_val;
      logic [XLEN-1:0] rs2_val;
      logic [XLEN-1:0] imm;
      kind_e           kind;
      alu_e            alu;
      logic            use_imm;
      logic [2:0]      funct3;
      logic [3:0]      mem_op;
      logic            rf_wr;
   } idex_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic [4:0]      rd;
      logic            rf_wr;
      logic [XLEN-1:0] result;
      logic [3:0]      mem_op;
      logic [XLEN-1:0] store_data;
   } exmem_t;

   logic [XLEN-1:0] imem_q [IMEM_DEPTH];
   logic [XLEN-1:0] rf_q   [NREG];
   logic [XLEN-1:0] pc_q, pc_d;
   logic            ifid_valid_q, ifid_valid_d;
   logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
   logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
   idex_t           idex_q, idex_d, dec;
   exmem_t          exmem_q, exmem_d;

   // ALU opcode from funct3 plus the SUB/SRA select bit
   function automatic alu_e alu_sel(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0:    return alt ? A_SUB : A_ADD;
         3'd1:    return A_SLL;
         3'd2:    return A_SLT;
         3'd3:    return A_SLTU;
         3'd4:    return A_XOR;
         3'd5:    return alt ? A_SRA : A_SRL;
         3'd6:    return A_OR;
         default: return A_AND;
      endcase
   endfunction

   // ---------------- ID: decode and register read ----------------
   logic [6:0]      opcode, f7;
   logic [2:0]      f3, fmt;
   logic [4:0]      rs1_a, rs2_a;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_v, rs2_v;
   logic            legal, has_rd;

   assign opcode = ifid_instr_q[6:0];
   assign f3     = ifid_instr_q[14:12];
   assign f7     = ifid_instr_q[31:25];
   assign rs1_a  = ifid_instr_q[19:15];
   assign rs2_a  = ifid_instr_q[24:20];
   assign imm_i  = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
   assign imm_s  = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
   assign imm_b  = {{19{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                    ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};
   assign imm_u  = {ifid_instr_q[31:12], 12'd0};
   assign imm_j  = {{11{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[19:12],
                    ifid_instr_q[20], ifid_instr_q[30:21], 1'b0};

   // Write-first bypass: a same-cycle writeback is visible to the read
   assign rs1_v = (rs1_a == 5'd0) ? '0 : (wb_we_i && wb_rd_i == rs1_a) ? wb_data_i : rf_q[rs1_a];
   assign rs2_v = (rs2_a == 5'd0) ? '0 : (wb_we_i && wb_rd_i == rs2_a) ? wb_data_i : rf_q[rs2_a];

   always_comb begin
      dec         = '0;
      dec.pc      = ifid_pc_q;
      dec.instr   = ifid_instr_q;
      dec.rs1_val = rs1_v;
      dec.rs2_val = rs2_v;
      fmt         = 3'd7;
      legal       = 1'b0;
      has_rd      = 1'b0;
      case (opcode)
         7'b0110011: begin
            legal   = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            fmt     = 3'd0;
            has_rd  = 1'b1;
            dec.alu = alu_sel(f3, f7[5]);
         end
         7'b0010011: begin
            legal   = !((f3 == 3'd1 && f7 != 7'h00) ||
                        (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20));
            fmt     = 3'd1;
            has_rd  = 1'b1;
            dec.imm = imm_i;
            dec.use_imm = 1'b1;
            dec.alu = alu_sel(f3, (f3 == 3'd5) && ifid_instr_q[30]);
         end
         7'b0000011: begin
            legal    = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            fmt      = 3'd1;
            has_rd   = 1'b1;
            dec.kind = K_LOAD;
            dec.imm  = imm_i;
            dec.mem_op = (f3 == 3'd4) ? 4'd4 : (f3 == 3'd5) ? 4'd5 : 4'(f3) + 4'd1;
         end
         7'b0100011: begin
            legal    = (f3 <= 3'd2);
            fmt      = 3'd2;
            dec.kind = K_STORE;
            dec.imm  = imm_s;
            dec.mem_op = 4'(f3) + 4'd6;
         end
         7'b1100011: begin
            legal    = (f3 != 3'd2) && (f3 != 3'd3);
            fmt      = 3'd3;
            dec.kind = K_BRANCH;
            dec.imm  = imm_b;
         end
         7'b1100111: begin
            legal    = (f3 == 3'd0);
            fmt      = 3'd1;
            has_rd   = 1'b1;
            dec.kind = K_JALR;
            dec.imm  = imm_i;
         end
         7'b1101111: begin
            legal = 1'b1; fmt = 3'd5; has_rd = 1'b1; dec.kind = K_JAL; dec.imm = imm_j;
         end
         7'b0110111: begin
            legal = 1'b1; fmt = 3'd4; has_rd = 1'b1; dec.kind = K_LUI; dec.imm = imm_u;
         end
         7'b0010111: begin
            legal = 1'b1; fmt = 3'd4; has_rd = 1'b1; dec.kind = K_AUIPC; dec.imm = imm_u;
         end
         default: ;
      endcase
      if (!legal) fmt = 3'd7;
      dec.funct3 = f3;
      dec.rd     = has_rd ? ifid_instr_q[11:7] : 5'd0;
      dec.rf_wr  = has_rd;
      dec.valid  = ifid_valid_q && legal;
      // Anything not valid leaves ID as a canonical bubble
      if (!dec.valid) begin
         dec       = '0;
         dec.instr = NOP;
      end
   end

   // ---------------- EX: ALU, branch resolution ----------------
   logic [XLEN-1:0] alu_b, alu_res, pc_imm, target, ex_res;
   logic [4:0]      shamt;
   logic            br_cond, taken;

   assign alu_b  = idex_q.use_imm ? idex_q.imm : idex_q.rs2_val;
   assign shamt  = alu_b[4:0];
   assign pc_imm = idex_q.pc + idex_q.imm;

   always_comb begin
      case (idex_q.alu)
         A_ADD:   alu_res = idex_q.rs1_val + alu_b;
         A_SUB:   alu_res = idex_q.rs1_val - alu_b;
         A_SLL:   alu_res = idex_q.rs1_val << shamt;
         A_SLT:   alu_res = {31'd0, $signed(idex_q.rs1_val) < $signed(alu_b)};
         A_SLTU:  alu_res = {31'd0, idex_q.rs1_val < alu_b};
         A_XOR:   alu_res = idex_q.rs1_val ^ alu_b;
         A_SRL:   alu_res = idex_q.rs1_val >> shamt;
         A_SRA:   alu_res = $signed(idex_q.rs1_val) >>> shamt;
         A_OR:    alu_res = idex_q.rs1_val | alu_b;
         default: alu_res = idex_q.rs1_val & alu_b;
      endcase
   end

   always_comb begin
      case (idex_q.funct3)
         3'd0:    br_cond = (idex_q.rs1_val == idex_q.rs2_val);
         3'd1:    br_cond = (idex_q.rs1_val != idex_q.rs2_val);
         3'd4:    br_cond = ($signed(idex_q.rs1_val) <  $signed(idex_q.rs2_val));
         3'd5:    br_cond = ($signed(idex_q.rs1_val) >= $signed(idex_q.rs2_val));
         3'd6:    br_cond = (idex_q.rs1_val <  idex_q.rs2_val);
         3'd7:    br_cond = (idex_q.rs1_val >= idex_q.rs2_val);
         default: br_cond = 1'b0;
      endcase
   end

   assign target = (idex_q.kind == K_JALR) ? ((idex_q.rs1_val + idex_q.imm) & ~32'd1) : pc_imm;
   assign taken  = idex_q.valid && (idex_q.kind == K_JAL || idex_q.kind == K_JALR ||
                                    (idex_q.kind == K_BRANCH && br_cond));
   assign flush_o = taken;

   always_comb begin
      case (idex_q.kind)
         K_LUI:           ex_res = idex_q.imm;
         K_AUIPC,
         K_BRANCH:        ex_res = pc_imm;
         K_LOAD, K_STORE: ex_res = idex_q.rs1_val + idex_q.imm;
         K_JAL, K_JALR:   ex_res = idex_q.pc + 32'd4;
         default:         ex_res = alu_res;
      endcase
   end

   always_comb begin
      exmem_d       = '0;
      exmem_d.instr = NOP;
      if (idex_q.valid) begin
         exmem_d.valid      = 1'b1;
         exmem_d.pc         = idex_q.pc;
         exmem_d.instr      = idex_q.instr;
         exmem_d.rd         = idex_q.rd;
         exmem_d.rf_wr      = idex_q.rf_wr && (idex_q.rd != 5'd0);
         exmem_d.result     = ex_res;
         exmem_d.mem_op     = idex_q.mem_op;
         exmem_d.store_data = (idex_q.kind == K_STORE) ? idex_q.rs2_val : '0;
      end
   end

   // ---------------- Pipeline control: flush beats stall ----------------
   always_comb begin
      pc_d         = pc_q + 32'd4;
      ifid_valid_d = 1'b1;
      ifid_instr_d = imem_q[pc_q[9:2]];
      ifid_pc_d    = pc_q;
      idex_d       = dec;
      if (taken) begin
         pc_d         = target & ~32'd3;
         ifid_valid_d = 1'b0;
         ifid_instr_d = NOP;
         ifid_pc_d    = '0;
         idex_d       = '0;
         idex_d.instr = NOP;
      end else if (stall_i) begin
         pc_d         = pc_q;
         ifid_valid_d = ifid_valid_q;
         ifid_instr_d = ifid_instr_q;
         ifid_pc_d    = ifid_pc_q;
         idex_d       = '0;
         idex_d.instr = NOP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= '0;
         ifid_valid_q  <= 1'b0;
         ifid_instr_q  <= NOP;
         ifid_pc_q     <= '0;
         idex_q        <= '0;
         idex_q.instr  <= NOP;
         exmem_q       <= '0;
         exmem_q.instr <= NOP;
      end else begin
         pc_q         <= pc_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         idex_q       <= idex_d;
         exmem_q      <= exmem_d;
      end
   end

   // Instruction memory: byte-enabled write, read is combinational (old data)
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < IMEM_DEPTH; i++) imem_q[8'(i)] <= '0;
      end else begin
         for (int b = 0; b < 4; b++)
            if (imem_wen_i[b]) imem_q[imem_waddr_i][8*b +: 8] <= imem_wdata_i[8*b +: 8];
      end
   end

   // Register file; x0 is never written
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) rf_q[5'(i)] <= '0;
      end else if (wb_we_i && wb_rd_i != 5'd0) begin
         rf_q[wb_rd_i] <= wb_data_i;
      end
   end

   assign instr_o         = ifid_instr_q;
   assign format_o        = fmt;
   assign ex_valid_o      = exmem_q.valid;
   assign ex_pc_o         = exmem_q.pc;
   assign ex_instr_o      = exmem_q.instr;
   assign ex_rd_o         = exmem_q.rd;
   assign ex_rf_wr_en_o   = exmem_q.rf_wr;
   assign ex_result_o     = exmem_q.result;
   assign ex_mem_op_o     = exmem_q.mem_op;
   assign ex_store_data_o = exmem_q.store_data;
endmodule

// File: tb/tb_if_id_ex_pipeline.sv
// Testbench for if_id_ex_pipeline: single-instruction vector table plus
// cycle-exact sequences for bypass, stall, flush, illegal and reset.
module tb_if_id_ex_pipeline;
   logic        clk = 1'b0;
   logic        rst, stall_i, wb_we_i;
   logic [3:0]  imem_wen_i;
   logic [7:0]  imem_waddr_i;
   logic [31:0] imem_wdata_i, wb_data_i;
   logic [4:0]  wb_rd_i;
   logic [31:0] instr_o, ex_pc_o, ex_instr_o, ex_result_o, ex_store_data_o;
   logic [2:0]  format_o;
   logic        flush_o, ex_valid_o, ex_rf_wr_en_o;
   logic [4:0]  ex_rd_o;
   logic [3:0]  ex_mem_op_o;

   int checks = 0;
   int errors = 0;

   if_id_ex_pipeline dut (
      .clk(clk), .rst(rst), .imem_wen_i(imem_wen_i), .imem_waddr_i(imem_waddr_i),
      .imem_wdata_i(imem_wdata_i), .stall_i(stall_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i),
      .wb_data_i(wb_data_i), .instr_o(instr_o), .format_o(format_o), .flush_o(flush_o),
      .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_instr_o(ex_instr_o), .ex_rd_o(ex_rd_o),
      .ex_rf_wr_en_o(ex_rf_wr_en_o), .ex_result_o(ex_result_o), .ex_mem_op_o(ex_mem_op_o),
      .ex_store_data_o(ex_store_data_o));

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [4:0]  ra;   logic [31:0] va;
      logic [4:0]  rb;   logic [31:0] vb;
      logic        vld;
      logic [2:0]  fmt;
      logic [4:0]  rd;
      logic        wr;
      logic [31:0] res;
      logic        chk_res;
      logic [3:0]  mop;
      logic [31:0] sdata;
      logic        flush;
   } vec_t;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] res;
      logic        chk_res;
   } exp_t;

   vec_t        vecs[$];
   vec_t        sb[$];
   exp_t        cq[$];
   logic [31:0] prog[$];

   // Instruction encoders
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
         input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction
   function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
         input logic [6:0] op);
      return {imm, rd, op};
   endfunction
   function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
   endfunction

   function automatic vec_t mk(input string n, input logic [31:0] ins,
         input logic [4:0] ra, input logic [31:0] va, input logic [4:0] rb, input logic [31:0] vb,
         input logic vld, input logic [2:0] fmt, input logic [4:0] rd, input logic wr,
         input logic [31:0] res, input logic chk_res, input logic [3:0] mop,
         input logic [31:0] sdata, input logic flush);
      vec_t v;
      v.name = n; v.instr = ins; v.ra = ra; v.va = va; v.rb = rb; v.vb = vb;
      v.vld = vld; v.fmt = fmt; v.rd = rd; v.wr = wr; v.res = res; v.chk_res = chk_res;
      v.mop = mop; v.sdata = sdata; v.flush = flush;
      return v;
   endfunction

   function automatic exp_t ex(input logic valid, input logic [31:0] pc, input logic [4:0] rd,
         input logic [31:0] res, input logic chk_res);
      exp_t e;
      e.valid = valid; e.pc = pc; e.rd = rd; e.res = res; e.chk_res = chk_res;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reset, load prog at word 0.., preload up to two registers, release stall.
   // Returns with inputs set so the next rising edge is the first fetch edge.
   task automatic start_prog(input logic [4:0] ra, input logic [31:0] va,
                             input logic [4:0] rb, input logic [31:0] vb);
      rst = 1'b1; stall_i = 1'b1; imem_wen_i = '0; wb_we_i = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      foreach (prog[i]) begin
         imem_wen_i = 4'hF; imem_waddr_i = 8'(i); imem_wdata_i = prog[i];
         @(negedge clk);
      end
      imem_wen_i = '0;
      if (ra != 5'd0) begin wb_we_i = 1'b1; wb_rd_i = ra; wb_data_i = va; @(negedge clk); end
      if (rb != 5'd0) begin wb_we_i = 1'b1; wb_rd_i = rb; wb_data_i = vb; @(negedge clk); end
      wb_we_i = 1'b0;
      stall_i = 1'b0;
   endtask

   // Advance one edge and compare EX/MEM against the next queued expectation
   task automatic step_cmp(input string nm);
      exp_t e;
      @(negedge clk);
      if (cq.size() == 0) begin
         chk({nm, " queue"}, 32'd0, 32'd1);
      end else begin
         e = cq.pop_front();
         chk({nm, " valid"}, 32'(ex_valid_o), 32'(e.valid));
         if (e.valid) begin
            chk({nm, " pc"}, ex_pc_o, e.pc);
            chk({nm, " rd"}, 32'(ex_rd_o), 32'(e.rd));
            if (e.chk_res) chk({nm, " result"}, ex_result_o, e.res);
         end
      end
   endtask

   initial begin
      vec_t v;
      int   lat;
      logic seen_flush;

      rst = 1'b1; stall_i = 1'b0; wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
      imem_wen_i = '0; imem_waddr_i = '0; imem_wdata_i = '0;
      @(negedge clk); @(negedge clk);
      chk("reset instr_o", instr_o, 32'h13);
      chk("reset format_o", 32'(format_o), 32'd1);
      chk("reset ex_valid", 32'(ex_valid_o), 32'd0);
      chk("reset ex_instr", ex_instr_o, 32'h13);
      chk("reset ex_result", ex_result_o, 32'd0);
      chk("reset flush", 32'(flush_o), 32'd0);

      //        name     instr                                   ra va            rb vb         vld fmt rd wr res          cr mop sdata        fl
      vecs.push_back(mk("addi",  enc_i(14, 0, 0, 1, 7'h13),         0, 0,           0, 0,         1, 1, 1, 1, 32'd14,      1, 0, 0,            0));
      vecs.push_back(mk("lw",    enc_i(12, 6, 2, 7, 7'h03),         6, 32'h100,     0, 0,         1, 1, 7, 1, 32'h10C,     1, 3, 0,            0));
      vecs.push_back(mk("sub",   enc_r(7'h20, 5, 4, 0, 3),          4, 10,          5, 3,         1, 0, 3, 1, 32'd7,       1, 0, 0,            0));
      vecs.push_back(mk("sra",   enc_r(7'h20, 5, 4, 5, 3),          4, 32'h80000000,5, 32'h24,    1, 0, 3, 1, 32'hF8000000,1, 0, 0,            0));
      vecs.push_back(mk("slt",   enc_r(7'h00, 5, 4, 2, 3),          4, 32'hFFFFFFFF,5, 1,         1, 0, 3, 1, 32'd1,       1, 0, 0,            0));
      vecs.push_back(mk("sltu",  enc_r(7'h00, 5, 4, 3, 3),          4, 1,           5, 32'hFFFFFFFF,1,0, 3, 1, 32'd1,       1, 0, 0,            0));
      vecs.push_back(mk("sw",    enc_s(-4, 5, 4, 2),                4, 32'h200,     5, 32'hDEADBEEF,1,2, 0, 0, 32'h1FC,     1, 8, 32'hDEADBEEF, 0));
      vecs.push_back(mk("lui",   enc_u(20'h12345, 9, 7'h37),        0, 0,           0, 0,         1, 4, 9, 1, 32'h12345000,1, 0, 0,            0));
      vecs.push_back(mk("auipc", enc_u(20'h00001, 9, 7'h17),        0, 0,           0, 0,         1, 4, 9, 1, 32'h1000,    1, 0, 0,            0));
      vecs.push_back(mk("addi_x0", enc_i(5, 1, 0, 0, 7'h13),        1, 7,           0, 0,         1, 1, 0, 0, 32'd12,      1, 0, 0,            0));
      vecs.push_back(mk("jalr",  enc_i(3, 4, 0, 1, 7'h67),          4, 32'h100,     0, 0,         1, 1, 1, 1, 32'd4,       1, 0, 0,            1));
      vecs.push_back(mk("xori",  enc_i(-1, 4, 4, 3, 7'h13),         4, 32'h0F,      0, 0,         1, 1, 3, 1, 32'hFFFFFFF0,1, 0, 0,            0));
      vecs.push_back(mk("bne",   enc_b(8, 5, 4, 1),                 4, 1,           5, 2,         1, 3, 0, 0, 0,           0, 0, 0,            1));
      vecs.push_back(mk("blt_nt",enc_b(8, 5, 4, 4),                 4, 5,           5, -3,        1, 3, 0, 0, 0,           0, 0, 0,            0));
      vecs.push_back(mk("slli",  enc_i(31, 4, 1, 3, 7'h13),         4, 3,           0, 0,         1, 1, 3, 1, 32'h80000000,1, 0, 0,            0));
      vecs.push_back(mk("lbu",   enc_i(-1, 4, 4, 8, 7'h03),         4, 32'h10,      0, 0,         1, 1, 8, 1, 32'hF,       1, 4, 0,            0));
      vecs.push_back(mk("srai",  enc_i(32'h404, 4, 5, 3, 7'h13),    4, 32'h80000000,0, 0,         1, 1, 3, 1, 32'hF8000000,1, 0, 0,            0));
      vecs.push_back(mk("ecall", 32'h00000073,                      0, 0,           0, 0,         0, 7, 0, 0, 0,           0, 0, 0,            0));

      foreach (vecs[k]) begin
         v = vecs[k];
         prog = '{v.instr};
         start_prog(v.ra, v.va, v.rb, v.vb);
         sb.push_back(v);
         lat = 0; seen_flush = 1'b0;
         for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) chk({v.name, " format"}, 32'(format_o), 32'(v.fmt));
            if (ex_valid_o) begin lat = c; break; end
            if (flush_o) seen_flush = 1'b1;
         end
         v = sb.pop_front();
         if (!v.vld) begin
            chk({v.name, " no valid"}, 32'(lat), 32'd0);
         end else if (lat == 0) begin
            chk({v.name, " timeout"}, 32'd0, 32'd1);
         end else begin
            chk({v.name, " latency"}, 32'(lat), 32'd3);
            chk({v.name, " pc"}, ex_pc_o, 32'd0);
            chk({v.name, " instr"}, ex_instr_o, v.instr);
            chk({v.name, " rd"}, 32'(ex_rd_o), 32'(v.rd));
            chk({v.name, " wr"}, 32'(ex_rf_wr_en_o), 32'(v.wr));
            if (v.chk_res) chk({v.name, " result"}, ex_result_o, v.res);
            chk({v.name, " mem_op"}, 32'(ex_mem_op_o), 32'(v.mop));
            if (v.mop >= 4'd6) chk({v.name, " store_data"}, ex_store_data_o, v.sdata);
            chk({v.name, " flush"}, 32'(seen_flush), 32'(v.flush));
         end
      end

      // Write-first bypass while addi x7,x2,5 sits in ID
      prog = '{enc_i(5, 2, 0, 7, 7'h13)};
      start_prog(0, 0, 0, 0);
      @(negedge clk);
      wb_we_i = 1'b1; wb_rd_i = 5'd2; wb_data_i = 32'd5;
      @(negedge clk);
      wb_we_i = 1'b0;
      @(negedge clk);
      chk("bypass valid", 32'(ex_valid_o), 32'd1);
      chk("bypass result", ex_result_o, 32'd10);

      // Two-cycle stall with ori in IF/ID
      prog = '{enc_i(1, 0, 0, 1, 7'h13), enc_i(32'h55, 0, 6, 2, 7'h13), enc_i(3, 0, 0, 3, 7'h13)};
      start_prog(0, 0, 0, 0);
      @(negedge clk); @(negedge clk);
      chk("stall instr pre", instr_o, prog[1]);
      stall_i = 1'b1;
      cq.push_back(ex(1, 0, 1, 1, 1));
      cq.push_back(ex(0, 0, 0, 0, 0));
      step_cmp("stall e3");
      chk("stall instr e3", instr_o, prog[1]);
      step_cmp("stall e4");
      chk("stall instr e4", instr_o, prog[1]);
      stall_i = 1'b0;
      cq.push_back(ex(0, 0, 0, 0, 0));
      cq.push_back(ex(1, 4, 2, 32'h55, 1));
      cq.push_back(ex(1, 8, 3, 3, 1));
      repeat (3) step_cmp("stall tail");

      // Taken beq at PC 8 squashes two, resumes at 0x18; then reset mid-flight
      prog = '{enc_i(1, 0, 0, 1, 7'h13), enc_i(2, 0, 0, 2, 7'h13), enc_b(16, 0, 0, 0),
               enc_i(3, 0, 0, 3, 7'h13), enc_i(4, 0, 0, 4, 7'h13), enc_i(5, 0, 0, 5, 7'h13),
               enc_i(6, 0, 0, 6, 7'h13), enc_i(7, 0, 0, 7, 7'h13)};
      start_prog(0, 0, 0, 0);
      cq.push_back(ex(0, 0, 0, 0, 0));
      cq.push_back(ex(0, 0, 0, 0, 0));
      cq.push_back(ex(1, 0, 1, 1, 1));
      cq.push_back(ex(1, 4, 2, 2, 1));
      repeat (4) step_cmp("br pre");
      chk("br flush in EX", 32'(flush_o), 32'd1);
      cq.push_back(ex(1, 8, 0, 0, 0));
      step_cmp("br beq");
      chk("br flush after", 32'(flush_o), 32'd0);
      cq.push_back(ex(0, 0, 0, 0, 0));
      cq.push_back(ex(0, 0, 0, 0, 0));
      cq.push_back(ex(1, 32'h18, 6, 6, 1));
      cq.push_back(ex(1, 32'h1C, 7, 7, 1));
      repeat (4) step_cmp("br post");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst ex_valid", 32'(ex_valid_o), 32'd0);
      chk("midrst ex_instr", ex_instr_o, 32'h13);
      chk("midrst instr_o", instr_o, 32'h13);
      chk("midrst flush", 32'(flush_o), 32'd0);

      // Illegal zero word, then jal x1,+8 at PC 4
      prog = '{32'h0, enc_j(8, 1), enc_i(3, 0, 0, 3, 7'h13), enc_i(4, 0, 0, 4, 7'h13)};
      start_prog(0, 0, 0, 0);
      cq.push_back(ex(0, 0, 0, 0, 0));
      step_cmp("ill e1");
      chk("ill format", 32'(format_o), 32'd7);
      cq.push_back(ex(0, 0, 0, 0, 0));
      cq.push_back(ex(0, 0, 0, 0, 0));
      repeat (2) step_cmp("ill e2e3");
      chk("jal flush", 32'(flush_o), 32'd1);
      cq.push_back(ex(1, 4, 1, 8, 1));
      cq.push_back(ex(0, 0, 0, 0, 0));
      cq.push_back(ex(0, 0, 0, 0, 0));
      cq.push_back(ex(1, 32'hC, 4, 4, 1));
      repeat (4) step_cmp("jal");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
